shot_timer: RTL and testbench

Arm/capture/readout controller for the acoustic sensor channels. Sits on the 8 MHz side downstream of the per-channel slope detectors. Distributes the slope threshold configuration to them, waits for the first detect, then timestamps every channel's first rising detect within a programmable window. Streams the per-channel results out through a valid/ready handshake.

---
 rtl/shot_pkg.sv | 17 +
 rtl/shot_chan.sv | 40 ++++
 rtl/shot_timer.sv | 192 +++++++++++++++++++
 tb/tb_shot_timer.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shot_pkg.sv
// Shared types and constants for the shot_timer capture controller.
package shot_pkg;

    localparam int NCH_DEF = 4;
    localparam int CW_DEF  = 16;

    // Timestamp reported for a channel that never detected; sliced to CW bits by users.
    localparam logic [63:0] TIME_NOHIT = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        READOUT = 2'd3
    } state_t;

endpackage

// File: rtl/shot_chan.sv
// One sensor channel: detect-level edge detector plus the first-hit record.
module shot_chan
    import shot_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk8M,
    input  logic          reset,
    input  logic          det,
    input  logic          clear,
    input  logic          cap_en,
    input  logic [CW-1:0] cnt,
    output logic          rise,
    output logic          hit,
    output logic [CW-1:0] stamp
);

    logic det_q;

    // Registered copy of the detect level, tracked in every state so a level
    // that is already high when the shot is armed never looks like a rise.
    always_ff @(posedge clk8M) begin
        if (reset) det_q <= 1'b0;
        else       det_q <= det;
    end

    assign rise = det & ~det_q;

    // First rise while capturing is recorded; later rises are ignored.
    always_ff @(posedge clk8M) begin
        if (reset || clear) begin
            hit   <= 1'b0;
            stamp <= '0;
        end else if (cap_en && rise && !hit) begin
            hit   <= 1'b1;
            stamp <= cnt;
        end
    end

endmodule

// File: rtl/shot_timer.sv
// Arm/capture/readout controller for the acoustic sensor channels.
// Optional feature: define SHOT_TIMER_TIMEOUT_EN to give up an armed shot
// after arm_timeout cycles without any detect.
//
// Readout handshake: an entry transfers on a clock edge where rd_valid and
// rd_ready are both high; while rd_ready is low the entry (rd_ch, rd_hit,
// rd_time) is held unchanged and rd_valid stays high until it transfers.
module shot_timer
    import shot_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic           clk8M,
    input  logic           reset,
    input  logic           arm,
    input  logic           abort,
    input  logic [5:0]     cfg_slope,
    input  logic           cfg_slope_neg,
    input  logic [CW-1:0]  window,
    input  logic [CW-1:0]  arm_timeout,
    input  logic [NCH-1:0] det,
    output logic [5:0]     slope,
    output logic           slope_neg,
    output logic           armed,
    output logic           rd_valid,
    input  logic           rd_ready,
    output logic [2:0]     rd_ch,
    output logic           rd_hit,
    output logic [CW-1:0]  rd_time,
    output logic           done,
    output logic           timeout,
    output logic [1:0]     dbg_state
);

    localparam logic [2:0] LAST_CH = 3'(NCH - 1);

    state_t         state, state_d;
    logic [CW-1:0]  cnt, win_q;
    logic [2:0]     rd_idx;
    logic [NCH-1:0] rise, hit, hit_now;
    logic [CW-1:0]  stamp [NCH];
    logic           capturing, any_rise, all_hit, tmo_hit;
    logic           chan_clr, arm_ok, load_cnt, rd_adv, done_d, timeout_d;
    logic           sel_hit;
    logic [CW-1:0]  sel_stamp;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        shot_chan #(.CW(CW)) u_chan (
            .clk8M  (clk8M),
            .reset  (reset),
            .det    (det[g]),
            .clear  (chan_clr),
            .cap_en (capturing),
            .cnt    (cnt),
            .rise   (rise[g]),
            .hit    (hit[g]),
            .stamp  (stamp[g])
        );
    end

    // In ARMED cnt is held at zero, so the first detect stamps time 0.
    assign capturing = (state == ARMED) || (state == CAPTURE);
    assign any_rise  = |rise;
    assign hit_now   = hit | (rise & {NCH{capturing}});
    assign all_hit   = &hit_now;

`ifdef SHOT_TIMER_TIMEOUT_EN
    logic [CW-1:0] tcnt;

    // Cycles spent in ARMED since entry; restarts on every new entry.
    always_ff @(posedge clk8M) begin
        if (reset)                                   tcnt <= '0;
        else if (state == ARMED && state_d == ARMED) tcnt <= tcnt + 1'b1;
        else                                         tcnt <= '0;
    end

    assign tmo_hit = (arm_timeout != '0) && (tcnt == arm_timeout - 1'b1);
`else
    logic unused_arm_timeout;
    assign unused_arm_timeout = ^arm_timeout;
    assign tmo_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk8M) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Next-state and per-cycle control strobes; abort overrides everything.
    always_comb begin
        state_d   = state;
        chan_clr  = 1'b0;
        arm_ok    = 1'b0;
        load_cnt  = 1'b0;
        rd_adv    = 1'b0;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        case (state)
            IDLE: begin
                if (arm && !abort) begin
                    arm_ok   = 1'b1;
                    chan_clr = 1'b1;
                    state_d  = ARMED;
                end
            end
            ARMED: begin
                if (any_rise) begin
                    if (window == '0 || all_hit) begin
                        state_d = READOUT;
                    end else begin
                        load_cnt = 1'b1;
                        state_d  = CAPTURE;
                    end
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            CAPTURE: begin
                if (cnt == win_q || all_hit) state_d = READOUT;
            end
            READOUT: begin
                if (rd_ready) begin
                    rd_adv = 1'b1;
                    if (rd_idx == LAST_CH) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d   = IDLE;
            done_d    = 1'b0;
            timeout_d = 1'b0;
            rd_adv    = 1'b0;
        end
    end

    // Config latches, window counter, readout pointer and status pulses.
    always_ff @(posedge clk8M) begin
        if (reset) begin
            slope     <= '0;
            slope_neg <= 1'b0;
            cnt       <= '0;
            win_q     <= '0;
            rd_idx    <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            done    <= done_d;
            timeout <= timeout_d;
            if (arm_ok) begin
                slope     <= cfg_slope;
                slope_neg <= cfg_slope_neg;
            end
            if (load_cnt) begin
                cnt   <= {{(CW-1){1'b0}}, 1'b1};
                win_q <= window;
            end else if (state_d == CAPTURE) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (state_d != READOUT) rd_idx <= '0;
            else if (rd_adv)        rd_idx <= rd_idx + 3'd1;
        end
    end

    // Readout mux; outputs read as zero outside READOUT.
    always_comb begin
        sel_hit   = 1'b0;
        sel_stamp = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_idx == 3'(i)) begin
                sel_hit   = hit[i];
                sel_stamp = stamp[i];
            end
        end
    end

    assign armed     = capturing;
    assign rd_valid  = (state == READOUT);
    assign rd_ch     = rd_idx;
    assign rd_hit    = rd_valid & sel_hit;
    assign rd_time   = !rd_valid ? '0 : (sel_hit ? sel_stamp : TIME_NOHIT[CW-1:0]);
    assign dbg_state = state;

endmodule

// File: tb/tb_shot_timer.sv
// Self-checking bench for shot_timer: scenario tasks plus a readout scoreboard.
module tb_shot_timer;
    import shot_pkg::*;

    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int EW  = 3 + 1 + CW;

    logic           clk8M = 1'b0;
    logic           reset, arm, abort, cfg_slope_neg, rd_ready;
    logic [5:0]     cfg_slope;
    logic [CW-1:0]  window, arm_timeout;
    logic [NCH-1:0] det;
    logic [5:0]     slope;
    logic           slope_neg, armed, rd_valid, rd_hit, done, timeout;
    logic [2:0]     rd_ch;
    logic [CW-1:0]  rd_time;
    logic [1:0]     dbg_state;

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;

    shot_timer #(.NCH(NCH), .CW(CW)) dut (
        .clk8M         (clk8M),
        .reset         (reset),
        .arm           (arm),
        .abort         (abort),
        .cfg_slope     (cfg_slope),
        .cfg_slope_neg (cfg_slope_neg),
        .window        (window),
        .arm_timeout   (arm_timeout),
        .det           (det),
        .slope         (slope),
        .slope_neg     (slope_neg),
        .armed         (armed),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_ch         (rd_ch),
        .rd_hit        (rd_hit),
        .rd_time       (rd_time),
        .done          (done),
        .timeout       (timeout),
        .dbg_state     (dbg_state)
    );

    // Clock and global time limit.
    always #5 clk8M = ~clk8M;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every accepted entry is popped and compared in order.
    always @(negedge clk8M) begin
        if (reset === 1'b0 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_entry: got unexpected ch=%0d hit=%0d time=%h, required no entry",
                         rd_ch, rd_hit, rd_time);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({rd_ch, rd_hit, rd_time} !== mon_exp) begin
                    bad++;
                    $display("FAIL rd_entry: got ch=%0d hit=%0d time=%h, required ch=%0d hit=%0d time=%h",
                             rd_ch, rd_hit, rd_time, mon_exp[EW-1 -: 3], mon_exp[CW], mon_exp[CW-1:0]);
                end
            end
        end
    end

    function automatic logic [EW-1:0] ent(input int ch, input bit h, input int t);
        logic [CW-1:0] tv;
        tv = h ? CW'(t) : '1;
        return {3'(ch), h, tv};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk8M);
        #1;
    endtask

    task automatic do_arm(input logic [5:0] s, input logic neg, input int win);
        cfg_slope     = s;
        cfg_slope_neg = neg;
        window        = CW'(win);
        arm           = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    // Runs until done is seen or the budget expires; counts rd_valid cycles.
    task automatic run_until_done(input int budget, output bit seen, output int vcyc);
        seen = 1'b0;
        vcyc = 0;
        for (int i = 0; i < budget; i++) begin
            if (rd_valid === 1'b1) vcyc++;
            tick(1);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; arm = 1'b0; abort = 1'b0; cfg_slope = 6'd0; cfg_slope_neg = 1'b0;
        window = '0; arm_timeout = '0; det = '0; rd_ready = 1'b0;
        tick(3);
        total++;
        if ({slope, slope_neg, armed, rd_valid, rd_ch, rd_hit, rd_time, done, timeout} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got slope=%0d neg=%0d armed=%0d rv=%0d ch=%0d hit=%0d time=%h done=%0d to=%0d, required all 0",
                     slope, slope_neg, armed, rd_valid, rd_ch, rd_hit, rd_time, done, timeout);
        end
        reset = 1'b0;
        tick(1);
        total++;
        if (dbg_state !== IDLE || armed !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got state=%0d armed=%0d, required state=0 armed=0", dbg_state, armed);
        end
    endtask

    task automatic test_window_readout();
        bit seen;
        int vcyc;
        rd_ready = 1'b1;
        det = '0;
        do_arm(6'd5, 1'b0, 100);
        total++;
        if (slope !== 6'd5 || armed !== 1'b1) begin
            bad++;
            $display("FAIL arm_cfg: got slope=%0d armed=%0d, required slope=5 armed=1", slope, armed);
        end
        exp_q.push_back(ent(0, 1, 10));
        exp_q.push_back(ent(1, 1, 40));
        exp_q.push_back(ent(2, 1, 0));
        exp_q.push_back(ent(3, 0, 0));
        tick(4);  det[2] = 1'b1;
        tick(10); det[0] = 1'b1;
        tick(30); det[1] = 1'b1;
        total++;
        if (dbg_state !== CAPTURE || armed !== 1'b1) begin
            bad++;
            $display("FAIL window_capture_state: got state=%0d armed=%0d, required state=2 armed=1", dbg_state, armed);
        end
        run_until_done(200, seen, vcyc);
        total++;
        if (!seen || vcyc != NCH) begin
            bad++;
            $display("FAIL window_done: got done_seen=%0d valid_cycles=%0d, required 1 and %0d", seen, vcyc, NCH);
        end
        total++;
        if (rd_valid !== 1'b0 || dbg_state !== IDLE || exp_q.size() != 0) begin
            bad++;
            $display("FAIL window_after: got rv=%0d state=%0d left=%0d, required 0 0 0", rd_valid, dbg_state, exp_q.size());
        end
        tick(1);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse_width: got done=%0d, required 0", done);
        end
        det = '0;
        tick(2);
    endtask

    task automatic test_early_exit();
        bit seen;
        int vcyc;
        rd_ready = 1'b1;
        do_arm(6'd7, 1'b1, 100);
        exp_q.push_back(ent(0, 1, 2));
        exp_q.push_back(ent(1, 1, 0));
        exp_q.push_back(ent(2, 1, 3));
        exp_q.push_back(ent(3, 1, 1));
        tick(3); det[1] = 1'b1;
        tick(1); det[3] = 1'b1;
        tick(1); det[0] = 1'b1;
        tick(1); det[2] = 1'b1;
        tick(1);
        total++;
        if (rd_valid !== 1'b1 || rd_ch !== 3'd0 || slope_neg !== 1'b1) begin
            bad++;
            $display("FAIL early_exit: got rv=%0d ch=%0d neg=%0d, required 1 0 1", rd_valid, rd_ch, slope_neg);
        end
        run_until_done(20, seen, vcyc);
        total++;
        if (!seen || vcyc != NCH) begin
            bad++;
            $display("FAIL early_done: got done_seen=%0d valid_cycles=%0d, required 1 and %0d", seen, vcyc, NCH);
        end
        det = '0;
        tick(2);
    endtask

    task automatic test_back_to_back_backpressure();
        int d [NCH];
        bit hm [NCH];
        int mn, vcyc;
        bit seen, got;
        logic [EW-1:0] e1;
        rd_ready = 1'b0;
        do_arm(6'($urandom_range(0, 63)), 1'b0, 30);
        mn = 100;
        for (int i = 0; i < NCH; i++) begin
            d[i]  = $urandom_range(0, 20);
            hm[i] = ($urandom_range(0, 3) != 0);
        end
        hm[$urandom_range(0, NCH-1)] = 1'b1;
        for (int i = 0; i < NCH; i++) if (hm[i] && d[i] < mn) mn = d[i];
        for (int i = 0; i < NCH; i++) exp_q.push_back(ent(i, hm[i], d[i] - mn));
        e1 = ent(1, hm[1], d[1] - mn);
        tick(2);
        for (int c = 0; c <= 20; c++) begin
            for (int i = 0; i < NCH; i++) if (hm[i] && d[i] == c) det[i] = 1'b1;
            tick(1);
        end
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (rd_valid === 1'b1) begin got = 1'b1; break; end
            tick(1);
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL bp_wait_valid: got rv=%0d after 60 cycles, required 1", rd_valid);
        end
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            total++;
            if (rd_valid !== 1'b1 || {rd_ch, rd_hit, rd_time} !== e1) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got rv=%0d ch=%0d hit=%0d time=%h, required rv=1 entry %h",
                         k, rd_valid, rd_ch, rd_hit, rd_time, e1);
            end
            tick(1);
        end
        rd_ready = 1'b1;
        run_until_done(20, seen, vcyc);
        total++;
        if (!seen || vcyc != NCH - 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_done: got done_seen=%0d valid_cycles=%0d left=%0d, required 1 %0d 0",
                     seen, vcyc, exp_q.size(), NCH - 1);
        end
        det = '0;
        tick(2);
    endtask

    task automatic test_pre_high();
        bit seen;
        int vcyc;
        rd_ready = 1'b1;
        det = 4'b0010;
        tick(2);
        do_arm(6'd3, 1'b0, 20);
        exp_q.push_back(ent(0, 1, 0));
        exp_q.push_back(ent(1, 0, 0));
        exp_q.push_back(ent(2, 0, 0));
        exp_q.push_back(ent(3, 1, 0));
        tick(2);
        det = 4'b1011;
        tick(1);
        total++;
        if (dbg_state !== CAPTURE) begin
            bad++;
            $display("FAIL prehigh_capture: got state=%0d, required 2", dbg_state);
        end
        run_until_done(60, seen, vcyc);
        total++;
        if (!seen || exp_q.size() != 0) begin
            bad++;
            $display("FAIL prehigh_done: got done_seen=%0d left=%0d, required 1 0", seen, exp_q.size());
        end
        det = '0;
        tick(2);
    endtask

    task automatic test_abort();
        bit stray;
        rd_ready = 1'b1;
        do_arm(6'd12, 1'b0, 100);
        tick(2); det[0] = 1'b1;
        tick(5);
        total++;
        if (dbg_state !== CAPTURE) begin
            bad++;
            $display("FAIL abort_pre: got state=%0d, required 2", dbg_state);
        end
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        total++;
        if (dbg_state !== IDLE || armed !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: got state=%0d armed=%0d rv=%0d done=%0d, required 0 0 0 0",
                     dbg_state, armed, rd_valid, done);
        end
        stray = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (done !== 1'b0 || rd_valid !== 1'b0) stray = 1'b1;
            tick(1);
        end
        total++;
        if (stray || slope !== 6'd12) begin
            bad++;
            $display("FAIL abort_quiet: got stray=%0d slope=%0d, required 0 12", stray, slope);
        end
        det = '0;
        cfg_slope = 6'd20; arm = 1'b1; abort = 1'b1;
        tick(1);
        arm = 1'b0; abort = 1'b0;
        total++;
        if (dbg_state !== IDLE || slope !== 6'd12) begin
            bad++;
            $display("FAIL arm_abort_same: got state=%0d slope=%0d, required 0 12", dbg_state, slope);
        end
        do_arm(6'd9, 1'b1, 100);
        total++;
        if (slope !== 6'd9 || slope_neg !== 1'b1 || dbg_state !== ARMED) begin
            bad++;
            $display("FAIL rearm_slope: got slope=%0d neg=%0d state=%0d, required 9 1 1", slope, slope_neg, dbg_state);
        end
        cfg_slope = 6'd33; arm = 1'b1;
        tick(1);
        arm = 1'b0;
        total++;
        if (slope !== 6'd9) begin
            bad++;
            $display("FAIL arm_ignored: got slope=%0d, required 9", slope);
        end
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(1);
    endtask

    task automatic test_timeout();
        bit seen;
        int cyc;
        rd_ready = 1'b1;
        arm_timeout = CW'(50);
        do_arm(6'd4, 1'b0, 100);
`ifdef SHOT_TIMER_TIMEOUT_EN
        seen = 1'b0;
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (timeout === 1'b1) begin seen = 1'b1; cyc = i + 1; break; end
        end
        total++;
        if (!seen || cyc != 50 || dbg_state !== IDLE || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse: got seen=%0d cycles=%0d state=%0d rv=%0d, required 1 50 0 0",
                     seen, cyc, dbg_state, rd_valid);
        end
        tick(1);
        total++;
        if (timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_width: got timeout=%0d, required 0", timeout);
        end
`else
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (timeout !== 1'b0) seen = 1'b1;
            tick(1);
        end
        total++;
        if (seen || dbg_state !== ARMED) begin
            bad++;
            $display("FAIL no_timeout: got pulse=%0d state=%0d, required 0 1", seen, dbg_state);
        end
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
`endif
        arm_timeout = '0;
        tick(1);
    endtask

    task automatic test_reset_mid_readout();
        rd_ready = 1'b1;
        det = '0;
        do_arm(6'd15, 1'b1, 0);
        exp_q.push_back(ent(0, 0, 0));
        tick(2);
        det[2] = 1'b1;
        tick(1);
        total++;
        if (rd_valid !== 1'b1 || rd_ch !== 3'd0) begin
            bad++;
            $display("FAIL zero_window_readout: got rv=%0d ch=%0d, required 1 0", rd_valid, rd_ch);
        end
        tick(1);
        rd_ready = 1'b0;
        total++;
        if (rd_ch !== 3'd1 || rd_hit !== 1'b0 || rd_time !== 16'hFFFF) begin
            bad++;
            $display("FAIL mid_readout_entry: got ch=%0d hit=%0d time=%h, required 1 0 ffff", rd_ch, rd_hit, rd_time);
        end
        reset = 1'b1;
        tick(1);
        total++;
        if (rd_valid !== 1'b0 || dbg_state !== IDLE || slope !== 6'd0 || rd_ch !== 3'd0 || armed !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_readout: got rv=%0d state=%0d slope=%0d ch=%0d armed=%0d, required all 0",
                     rd_valid, dbg_state, slope, rd_ch, armed);
        end
        reset = 1'b0;
        det = '0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_window_readout();
        test_early_exit();
        test_back_to_back_backpressure();
        test_pre_high();
        test_abort();
        test_timeout();
        test_reset_mid_readout();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
